// File: rtl/rv32i_types.sv
// Shared front-end types: fetch-queue entries, ROB entries and fetch FSM states.
package rv32i_types;

  localparam int XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } pci_t;

  typedef struct packed {
    logic            valid;
    logic            done;
    logic [4:0]      rd;
    logic [XLEN-1:0] value;
  } rob_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DISCARD
  } fetch_state_t;

endpackage

// File: rtl/circ_queue.sv
// Power-of-two circular queue: front/rear pointers plus occupancy count, head read combinationally.
module circ_queue #(
  parameter int width = 64,
  parameter int size  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      enq,
  input  logic [width-1:0]          enq_data,
  input  logic                      deq,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(size+1)-1:0] count,
  output logic [width-1:0]          head
);

  localparam int PW = $clog2(size);
  localparam int CW = $clog2(size+1);

  logic [width-1:0] mem [size];
  logic [PW-1:0]    front, rear;
  logic             deq_ok, enq_ok;

  assign empty  = (count == '0);
  assign full   = (count == CW'(size));
  assign head   = mem[front];
  assign deq_ok = deq && !empty;
  // A full queue still accepts a write when the head leaves in the same cycle.
  assign enq_ok = enq && (!full || deq_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < size; i++) mem[i] <= '0;
      front <= '0;
      rear  <= '0;
      count <= '0;
    end else if (clear) begin
      front <= '0;
      rear  <= '0;
      count <= '0;
    end else begin
      if (enq_ok) begin
        mem[rear] <= enq_data;
        rear      <= rear + PW'(1);
      end
      if (deq_ok) front <= front + PW'(1);
      count <= count + CW'(enq_ok) - CW'(deq_ok);
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch FSM feeding a {pc, instr} queue; flushes redirect the PC and drop stale reads.
module fetch_queue
  import rv32i_types::*;
#(
  parameter int              width    = 32,
  parameter int              size     = 8,
  parameter logic [width-1:0] start_pc = 32'h00000060
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_read,
  output logic [width-1:0] imem_address,
  input  logic             imem_resp,
  input  logic [width-1:0] imem_rdata,
  input  logic             instr_q_dequeue,
  output logic             instr_q_empty,
  output pci_t             instr_q_data,
  input  logic             flush,
  input  logic [width-1:0] flush_pc
);

  localparam int CW = $clog2(size+1);

  fetch_state_t     state;
  logic [width-1:0] pc, pc_inc;
  logic             enq, deq_eff, deq_ok, full, empty, room_after_resp;
  logic [CW-1:0]    count, cnt_next;
  logic [2*width-1:0] head;

  always_comb begin
    deq_eff         = instr_q_dequeue && !flush;
    deq_ok          = deq_eff && !empty;
    enq             = (state == FETCH) && imem_resp && !flush;
    cnt_next        = count + CW'(enq) - CW'(deq_ok);
    room_after_resp = (cnt_next < CW'(size));
    pc_inc          = pc + width'(4);
  end

  circ_queue #(.width(2*width), .size(size)) u_q (
    .clk      (clk),
    .rst      (rst),
    .clear    (flush),
    .enq      (enq),
    .enq_data ({pc, imem_rdata}),
    .deq      (deq_eff),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .head     (head)
  );

  assign instr_q_empty = empty;
  assign instr_q_data  = pci_t'(head);

  // In DISCARD imem_address simply keeps the stale address of the abandoned read.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pc           <= start_pc;
      imem_read    <= 1'b0;
      imem_address <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (flush) begin
            pc           <= flush_pc;
            state        <= FETCH;
            imem_read    <= 1'b1;
            imem_address <= flush_pc;
          end else if (!full || deq_ok) begin
            state        <= FETCH;
            imem_read    <= 1'b1;
            imem_address <= pc;
          end
        end
        FETCH: begin
          if (flush) begin
            pc <= flush_pc;
            if (imem_resp) begin
              imem_address <= flush_pc;
            end else begin
              state <= DISCARD;
            end
          end else if (imem_resp) begin
            pc <= pc_inc;
            if (room_after_resp) begin
              imem_address <= pc_inc;
            end else begin
              state        <= IDLE;
              imem_read    <= 1'b0;
              imem_address <= '0;
            end
          end
        end
        DISCARD: begin
          if (imem_resp) begin
            state        <= FETCH;
            imem_address <= flush ? flush_pc : pc;
          end
          if (flush) pc <= flush_pc;
        end
        default: begin
          state        <= IDLE;
          imem_read    <= 1'b0;
          imem_address <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: fill/drain, wrap, flush in each state, reset mid-request.
module tb_fetch_queue;
  import rv32i_types::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_read;
  logic [31:0] imem_address;
  logic        imem_resp;
  logic [31:0] imem_rdata;
  logic        instr_q_dequeue;
  logic        instr_q_empty;
  pci_t        instr_q_data;
  logic        flush;
  logic [31:0] flush_pc;

  int passed = 0;
  int total  = 0;

  fetch_queue dut (
    .clk             (clk),
    .rst             (rst),
    .imem_read       (imem_read),
    .imem_address    (imem_address),
    .imem_resp       (imem_resp),
    .imem_rdata      (imem_rdata),
    .instr_q_dequeue (instr_q_dequeue),
    .instr_q_empty   (instr_q_empty),
    .instr_q_data    (instr_q_data),
    .flush           (flush),
    .flush_pc        (flush_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] drain_pc [7];
    drain_pc = '{32'h68, 32'h6C, 32'h70, 32'h74, 32'h78, 32'h7C, 32'h80};

    rst = 1'b1; imem_resp = 1'b0; imem_rdata = '0;
    instr_q_dequeue = 1'b0; flush = 1'b0; flush_pc = '0;
    step(); step();
    chk("rst_read",  {63'd0, imem_read},     64'd0);
    chk("rst_empty", {63'd0, instr_q_empty}, 64'd1);
    chk("rst_data",  instr_q_data,           64'd0);
    chk("rst_addr",  {32'd0, imem_address},  64'd0);

    // first request after reset
    rst = 1'b0;
    step();
    chk("first_read", {63'd0, imem_read},    64'd1);
    chk("first_addr", {32'd0, imem_address}, 64'h60);

    // single-cycle memory: visible one cycle after resp
    imem_resp = 1'b1; imem_rdata = 32'hDEAD0060;
    step();
    chk("first_visible", {63'd0, instr_q_empty}, 64'd0);
    chk("first_head",    instr_q_data,           {32'h60, 32'hDEAD0060});
    for (int k = 1; k < 8; k++) begin
      chk("seq_addr", {32'd0, imem_address}, 64'(32'h60 + 4*k));
      imem_rdata = 32'hDEAD0000 | imem_address;
      step();
    end
    imem_resp = 1'b0;
    chk("full_idle_read", {63'd0, imem_read},    64'd0);
    chk("full_idle_addr", {32'd0, imem_address}, 64'd0);
    chk("full_head",      instr_q_data,          {32'h60, 32'hDEAD0060});
    step();
    chk("full_stay_idle", {63'd0, imem_read}, 64'd0);

    // one dequeue reopens fetching at 0x80
    instr_q_dequeue = 1'b1;
    step();
    instr_q_dequeue = 1'b0;
    chk("refetch_read", {63'd0, imem_read},    64'd1);
    chk("refetch_addr", {32'd0, imem_address}, 64'h80);
    chk("deq_head",     instr_q_data,          {32'h64, 32'hDEAD0064});

    // same-cycle enqueue (into wrapped slot 0) and dequeue
    imem_resp = 1'b1; imem_rdata = 32'hDEAD0080; instr_q_dequeue = 1'b1;
    step();
    imem_resp = 1'b0; instr_q_dequeue = 1'b0;
    chk("both_head", instr_q_data,          {32'h68, 32'hDEAD0068});
    chk("both_addr", {32'd0, imem_address}, 64'h84);

    // drain in order; last entry comes from the wrapped rear slot
    for (int i = 0; i < 7; i++) begin
      chk("drain_head", instr_q_data, {drain_pc[i], 32'hDEAD0000 | drain_pc[i]});
      instr_q_dequeue = 1'b1;
      step();
    end
    instr_q_dequeue = 1'b0;
    chk("drained_empty", {63'd0, instr_q_empty}, 64'd1);
    chk("hold_addr",     {32'd0, imem_address},  64'h84);
    step();
    instr_q_dequeue = 1'b1;
    step();
    instr_q_dequeue = 1'b0;
    chk("deq_empty_ignored", {63'd0, instr_q_empty}, 64'd1);

    // flush while a 3-cycle read is pending
    imem_resp = 1'b1; imem_rdata = 32'hDEAD0084;
    step();
    imem_resp = 1'b0;
    chk("pre_flush_nonempty", {63'd0, instr_q_empty}, 64'd0);
    flush = 1'b1; flush_pc = 32'h200;
    step();
    flush = 1'b0;
    chk("flush_empty",    {63'd0, instr_q_empty}, 64'd1);
    chk("discard_read",   {63'd0, imem_read},     64'd1);
    chk("discard_addr",   {32'd0, imem_address},  64'h88);
    step();
    chk("discard_addr2",  {32'd0, imem_address},  64'h88);
    imem_resp = 1'b1; imem_rdata = 32'hBAD00088;
    step();
    imem_resp = 1'b0;
    chk("dropped_empty",  {63'd0, instr_q_empty}, 64'd1);
    chk("redirect_addr",  {32'd0, imem_address},  64'h200);

    // flush with same-cycle resp and dequeue
    imem_resp = 1'b1; imem_rdata = 32'hDEAD0200;
    step();
    chk("pre_flush2_head", instr_q_data, {32'h200, 32'hDEAD0200});
    flush = 1'b1; flush_pc = 32'h200; imem_rdata = 32'hBAD00204; instr_q_dequeue = 1'b1;
    step();
    flush = 1'b0; imem_resp = 1'b0; instr_q_dequeue = 1'b0;
    chk("flush2_empty", {63'd0, instr_q_empty}, 64'd1);
    chk("flush2_addr",  {32'd0, imem_address},  64'h200);
    step();
    chk("flush2_noenq", {63'd0, instr_q_empty}, 64'd1);

    // repeated flush in DISCARD only moves the PC
    flush = 1'b1; flush_pc = 32'h300;
    step();
    flush_pc = 32'h400;
    step();
    flush = 1'b0;
    chk("discard_hold", {32'd0, imem_address}, 64'h200);
    imem_resp = 1'b1; imem_rdata = 32'hBAD00200;
    step();
    chk("last_flush_addr", {32'd0, imem_address}, 64'h400);
    imem_rdata = 32'hDEAD0400;
    step();
    imem_resp = 1'b0;
    chk("last_flush_head", instr_q_data, {32'h400, 32'hDEAD0400});

    // reset mid-request overrides flush and resp
    rst = 1'b1; flush = 1'b1; flush_pc = 32'h500; imem_resp = 1'b1; instr_q_dequeue = 1'b1;
    step();
    rst = 1'b0; flush = 1'b0; imem_resp = 1'b0; instr_q_dequeue = 1'b0;
    chk("midrst_read",  {63'd0, imem_read},     64'd0);
    chk("midrst_empty", {63'd0, instr_q_empty}, 64'd1);
    chk("midrst_data",  instr_q_data,           64'd0);
    step();
    chk("post_rst_addr", {32'd0, imem_address}, 64'h60);

    // flush while IDLE goes straight to the flush target
    rst = 1'b1;
    step();
    rst = 1'b0; flush = 1'b1; flush_pc = 32'h700;
    step();
    flush = 1'b0;
    chk("idle_flush_read", {63'd0, imem_read},    64'd1);
    chk("idle_flush_addr", {32'd0, imem_address}, 64'h700);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
